reaction_sequencer: RTL

//   Control FSM for the reaction-timer game. On each start press it samples the free-running
//   13-bit pseudo-random generator and waits a random delay. It then lights the GO LED and

---
 rtl/reaction_timer_pkg.sv | 7 +
 rtl/ms_tick_gen.sv | 18 +
 rtl/reaction_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reaction_timer_pkg.sv
// reaction_timer_pkg: shared state encoding plus width and timeout defaults for the reaction timer.
package reaction_timer_pkg;
    localparam int LFSR_W_DEF     = 13;
    localparam int RT_W_DEF       = 14;
    localparam int TIMEOUT_MS_DEF = 9999;
    typedef enum logic [2:0] {IDLE, ARM, WAIT, GO, DONE, FAULT, TOUT} state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: 1 ms prescaler; tick is high in the cycle the count sits at TICK_DIV-1.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(TICK_DIV - 1);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reaction_sequencer.sv
// reaction_sequencer: reaction-timer game FSM (random delay, GO lamp, ms reaction count).
// Defining REACTION_BEST_TIME_EN adds the best_ms port tracking the fastest valid result.
module reaction_sequencer
    import reaction_timer_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int TIMEOUT_MS   = TIMEOUT_MS_DEF,
    parameter int LFSR_W       = LFSR_W_DEF,
    parameter int RT_W         = RT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              button,
    input  logic [LFSR_W-1:0] lfsr_value,
    output logic              led_go,
    output logic [RT_W-1:0]   rt_ms,
    output logic              rt_valid,
    output logic              early_fault,
    output logic              timeout,
    output logic              busy
`ifdef REACTION_BEST_TIME_EN
   ,output logic [RT_W-1:0]   best_ms
`endif
);
    state_t state_q, state_d;
    logic start_prev_q, btn_prev_q;
    logic [RT_W-1:0] delay_cnt_q, delay_cnt_d, rt_cnt_q, rt_cnt_d, rt_ms_q, rt_ms_d;
    logic led_go_q, led_go_d, rt_valid_q, rt_valid_d, early_fault_q, early_fault_d;
    logic timeout_q, timeout_d, busy_q, busy_d;
    logic start_rise, btn_rise, tick, clr;

    assign start_rise = start & ~start_prev_q;
    assign btn_rise   = button & ~btn_prev_q;
    // Restart the ms phase whenever a timed interval begins.
    assign clr = (state_d == WAIT || state_d == GO) && state_d != state_q;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        rt_cnt_d    = rt_cnt_q;
        rt_ms_d     = rt_ms_q;
        case (state_q)
            IDLE, DONE, FAULT, TOUT: begin
                if (start_rise) begin
                    state_d = ARM;
                    rt_ms_d = '0;
                end
            end
            ARM: begin
                delay_cnt_d = RT_W'(MIN_DELAY_MS) + RT_W'(lfsr_value);
                rt_cnt_d    = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (btn_rise) state_d = FAULT;
                else if (tick) begin
                    delay_cnt_d = delay_cnt_q - RT_W'(1);
                    if (delay_cnt_q <= RT_W'(1)) state_d = GO;
                end
            end
            GO: begin
                if (btn_rise) begin
                    state_d = DONE;
                    rt_ms_d = rt_cnt_q;
                end else if (tick) begin
                    rt_cnt_d = rt_cnt_q + RT_W'(1);
                    if (rt_cnt_d == RT_W'(TIMEOUT_MS)) begin
                        state_d = TOUT;
                        rt_ms_d = RT_W'(TIMEOUT_MS);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        led_go_d      = state_d == GO;
        rt_valid_d    = state_d == DONE;
        early_fault_d = state_d == FAULT;
        timeout_d     = state_d == TOUT;
        busy_d        = state_d inside {ARM, WAIT, GO};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            start_prev_q  <= 1'b0;
            btn_prev_q    <= 1'b0;
            delay_cnt_q   <= '0;
            rt_cnt_q      <= '0;
            rt_ms_q       <= '0;
            led_go_q      <= 1'b0;
            rt_valid_q    <= 1'b0;
            early_fault_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start;
            btn_prev_q    <= button;
            delay_cnt_q   <= delay_cnt_d;
            rt_cnt_q      <= rt_cnt_d;
            rt_ms_q       <= rt_ms_d;
            led_go_q      <= led_go_d;
            rt_valid_q    <= rt_valid_d;
            early_fault_q <= early_fault_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign led_go      = led_go_q;
    assign rt_ms       = rt_ms_q;
    assign rt_valid    = rt_valid_q;
    assign early_fault = early_fault_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

`ifdef REACTION_BEST_TIME_EN
    logic [RT_W-1:0] best_q, best_d;
    always_comb best_d = (state_d == DONE && state_q != DONE && rt_ms_d < best_q) ? rt_ms_d : best_q;
    always_ff @(posedge clk) begin
        if (rst) best_q <= '1;
        else     best_q <= best_d;
    end
    assign best_ms = best_q;
`endif
endmodule
